// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window feeder: FSM encodings,
// border-mode constants and a width helper.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int BORDER_ZERO      = 0;
  localparam int BORDER_REPLICATE = 1;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sobel_line_ram.sv
// One image row of pixels: synchronous write, combinational read at the
// same address, so a column can be read and overwritten in one cycle.
module sobel_line_ram
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 720,
  parameter int PIX_DWIDTH = 8,
  localparam int AW        = clog2(IMG_WIDTH)
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [PIX_DWIDTH-1:0] wdata,
  output logic [PIX_DWIDTH-1:0] rdata
);

  logic [PIX_DWIDTH-1:0] mem [IMG_WIDTH];

  // Store the incoming pixel at the current column.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_feeder.sv
// Turns a raster pixel stream into vertical WIN-pixel window columns,
// one per input pixel, with zero or replicate handling of rows outside
// the image.  Lane 0 of out_din is the top row of the window.
module sobel_window_feeder
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH   = 720,
  parameter int IMG_HEIGHT  = 540,
  parameter int PIX_DWIDTH  = 8,
  parameter int WIN         = 3,
  parameter int BORDER_MODE = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [PIX_DWIDTH-1:0]     in_dout,
  input  logic                      in_empty,
  output logic                      in_rd_en,
  output logic [WIN*PIX_DWIDTH-1:0] out_din,
  input  logic                      out_full,
  output logic                      out_wr_en,
  output logic                      frame_done
);

  localparam int HALF    = (WIN - 1) / 2;
  localparam int HALF_M1 = (HALF > 0) ? HALF - 1 : 0;
  localparam int CW      = clog2(IMG_WIDTH);
  localparam int RW      = clog2(IMG_HEIGHT);
  localparam int IW      = clog2(WIN);
  localparam int NLB     = (WIN > 1) ? WIN - 1 : 1;
  localparam int PW      = PIX_DWIDTH;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           col_reg, col_next;
  logic [RW-1:0]           row_reg, row_next;
  logic                    valid_reg, last_reg, done_reg;
  logic [WIN*PW-1:0]       data_reg;
  logic                    accept, run_like, pop, produce, last_col, row_end;
  logic [PW-1:0]           cur_pix;
  logic [PW-1:0]           lb_rd [NLB];
  logic [PW-1:0]           lb_wd [NLB];
  logic [PW-1:0]           tap [WIN];
  logic [WIN*PW-1:0]       column;
  logic [IW-1:0]           top_idx;
  int                      vrow;

  // The output stage can take a column when it is empty or draining.
  assign accept   = !valid_reg || !out_full;
  // With a one-row window there is nothing to pre-fill, so FILL acts as RUN.
  assign run_like = (state_reg == ST_RUN) || ((state_reg == ST_FILL) && (HALF == 0));
  assign row_end  = (col_reg == CW'(IMG_WIDTH - 1));

  // During FLUSH the missing bottom rows are synthesised as border pixels;
  // in replicate mode lb_rd[0] always holds the last real row (or a copy).
  assign cur_pix = (state_reg != ST_FLUSH) ? in_dout :
                   (BORDER_MODE == BORDER_REPLICATE) ? lb_rd[0] : '0;

  // Line buffers form a per-column shift chain: lb[0] is the previous row.
  for (genvar gi = 0; gi < WIN - 1; gi++) begin : g_lb
    sobel_line_ram #(
      .IMG_WIDTH  (IMG_WIDTH),
      .PIX_DWIDTH (PIX_DWIDTH)
    ) u_ram (
      .clock (clock),
      .we    (pop || produce),
      .addr  (col_reg),
      .wdata (lb_wd[gi]),
      .rdata (lb_rd[gi])
    );
    if (gi == 0) begin : g_head
      assign lb_wd[gi] = cur_pix;
    end else begin : g_chain
      assign lb_wd[gi] = lb_rd[gi-1];
    end
  end

  // Tap j is window row j before top-border substitution.
  for (genvar gi = 0; gi < WIN; gi++) begin : g_tap
    if (gi == WIN - 1) begin : g_cur
      assign tap[gi] = cur_pix;
    end else begin : g_old
      assign tap[gi] = lb_rd[WIN-2-gi];
    end
  end

  // Assemble the column; rows above the image take zero or row 0.
  always_comb begin
    vrow = 32'(row_reg);
    if (state_reg == ST_FLUSH) vrow = vrow + IMG_HEIGHT;
    top_idx = (vrow < WIN) ? IW'(WIN - 1 - vrow) : '0;
    column  = '0;
    for (int j = 0; j < WIN; j++) begin
      if (vrow + j < WIN - 1)
        column[j*PW +: PW] = (BORDER_MODE == BORDER_REPLICATE) ? tap[top_idx] : '0;
      else
        column[j*PW +: PW] = tap[j];
    end
  end

  // Next-state, counters, pop and produce decisions.
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    pop        = 1'b0;
    produce    = 1'b0;
    last_col   = 1'b0;
    case (state_reg)
      ST_FLUSH: begin
        produce  = accept;
        last_col = row_end && (row_reg == RW'(HALF_M1));
        if (produce) begin
          col_next = row_end ? '0 : col_reg + CW'(1);
          if (row_end) begin
            if (row_reg == RW'(HALF_M1)) begin
              row_next   = '0;
              state_next = ST_FILL;
            end else begin
              row_next = row_reg + RW'(1);
            end
          end
        end
      end
      default: begin
        if (run_like) begin
          pop      = !in_empty && accept;
          produce  = pop;
          last_col = row_end && (row_reg == RW'(IMG_HEIGHT - 1)) && (HALF == 0);
        end else begin
          pop = !in_empty;
        end
        if (pop) begin
          col_next = row_end ? '0 : col_reg + CW'(1);
          if (row_end) begin
            if (run_like) begin
              if (row_reg == RW'(IMG_HEIGHT - 1)) begin
                row_next   = '0;
                state_next = (HALF > 0) ? ST_FLUSH : ST_FILL;
              end else begin
                row_next   = row_reg + RW'(1);
                state_next = ST_RUN;
              end
            end else begin
              row_next = row_reg + RW'(1);
              if (row_reg == RW'(HALF_M1)) state_next = ST_RUN;
            end
          end
        end
      end
    endcase
  end

  // FSM state and raster counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_FILL;
      col_reg   <= '0;
      row_reg   <= '0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
    end
  end

  // Single-entry output stage; holds its column while downstream is full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (accept) begin
      valid_reg <= produce;
      if (produce) begin
        data_reg <= column;
        last_reg <= last_col;
      end
    end
  end

  // Pulse once the final column of the frame has actually been pushed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) done_reg <= 1'b0;
    else        done_reg <= out_wr_en && last_reg;
  end

  assign in_rd_en   = reset && pop;
  assign out_wr_en  = valid_reg && !out_full;
  assign out_din    = data_reg;
  assign frame_done = done_reg;

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Directed bench: zero/replicate 4x3 frames, backpressure, mid-frame
// reset, and back-to-back 6x6 WIN=5 frames with random gaps.
module tb_sobel_window_feeder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [7:0]  din_a = '0, din_b = '0, din_c = '0;
  logic        empty_a = 1'b1, empty_b = 1'b1, empty_c = 1'b1;
  logic        full_a = 1'b0, full_b = 1'b0, full_c = 1'b0;
  logic        rd_a, rd_b, rd_c, wr_a, wr_b, wr_c, fd_a, fd_b, fd_c;
  logic [23:0] dout_a, dout_b;
  logic [39:0] dout_c;

  sobel_window_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .PIX_DWIDTH(8), .WIN(3), .BORDER_MODE(0)) dut_a (
    .clock(clock), .reset(reset), .in_dout(din_a), .in_empty(empty_a), .in_rd_en(rd_a),
    .out_din(dout_a), .out_full(full_a), .out_wr_en(wr_a), .frame_done(fd_a));

  sobel_window_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .PIX_DWIDTH(8), .WIN(3), .BORDER_MODE(1)) dut_b (
    .clock(clock), .reset(reset), .in_dout(din_b), .in_empty(empty_b), .in_rd_en(rd_b),
    .out_din(dout_b), .out_full(full_b), .out_wr_en(wr_b), .frame_done(fd_b));

  sobel_window_feeder #(.IMG_WIDTH(6), .IMG_HEIGHT(6), .PIX_DWIDTH(8), .WIN(5), .BORDER_MODE(0)) dut_c (
    .clock(clock), .reset(reset), .in_dout(din_c), .in_empty(empty_c), .in_rd_en(rd_c),
    .out_din(dout_c), .out_full(full_c), .out_wr_en(wr_c), .frame_done(fd_c));

  typedef struct {
    int          dut;
    int          idx;
    logic [39:0] exp;
  } vec_t;

  vec_t        vecs [9];
  int          n_chk = 0;
  int          n_pass = 0;
  int          src_idx [3];
  int          src_lim [3];
  int          gap_pct [3];
  int          full_pct [3];
  int          fd_cnt [3];
  bit          pushed_prev [3];
  bit          chk_stall = 1'b0;
  logic [39:0] got_a [$];
  logic [39:0] got_b [$];
  logic [39:0] got_c [$];

  function automatic int d_w(input int d);    return (d == 2) ? 6 : 4; endfunction
  function automatic int d_h(input int d);    return (d == 2) ? 6 : 3; endfunction
  function automatic int d_half(input int d); return (d == 2) ? 2 : 1; endfunction

  function automatic logic [7:0] pix(input int d, input int idx);
    int f;
    f = idx % (d_w(d) * d_h(d));
    return 8'(16 * (f / d_w(d)) + (f % d_w(d)) + 1);
  endfunction

  // Reference column: window rows clamped (replicate) or zeroed outside the image.
  function automatic logic [39:0] model_col(input int d, input int k);
    logic [39:0] v;
    int f, r, c, rr, w, h;
    w = d_w(d);
    h = d_h(d);
    v = '0;
    f = k % (w * h);
    r = f / w;
    c = f % w;
    for (int j = 0; j < 2 * d_half(d) + 1; j++) begin
      rr = r - d_half(d) + j;
      if (rr < 0 || rr >= h) begin
        if (d != 1) continue;
        rr = (rr < 0) ? 0 : h - 1;
      end
      v[j*8 +: 8] = 8'(16 * rr + c + 1);
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic drive_inputs();
    empty_a = (src_idx[0] >= src_lim[0]) || ($urandom_range(0, 99) < gap_pct[0]);
    empty_b = (src_idx[1] >= src_lim[1]) || ($urandom_range(0, 99) < gap_pct[1]);
    empty_c = (src_idx[2] >= src_lim[2]) || ($urandom_range(0, 99) < gap_pct[2]);
    din_a   = pix(0, src_idx[0]);
    din_b   = pix(1, src_idx[1]);
    din_c   = pix(2, src_idx[2]);
    full_c  = ($urandom_range(0, 99) < full_pct[2]);
  endtask

  // One clock: sample outputs on the falling edge, advance sources after the rising edge.
  task automatic tick();
    bit pa, pb, pc;
    @(negedge clock);
    if (fd_a) begin
      fd_cnt[0]++;
      check("frame_done_a_after_last_push", 40'(pushed_prev[0] && (got_a.size() % 12 == 0)), 40'd1);
    end
    if (fd_b) begin
      fd_cnt[1]++;
      check("frame_done_b_after_last_push", 40'(pushed_prev[1] && (got_b.size() % 12 == 0)), 40'd1);
    end
    if (fd_c) begin
      fd_cnt[2]++;
      check("frame_done_c_after_last_push", 40'(pushed_prev[2] && (got_c.size() % 36 == 0)), 40'd1);
    end
    if (chk_stall) begin
      check("stall_rd_b", 40'(rd_b), 40'd0);
      check("stall_wr_b", 40'(wr_b), 40'd0);
      check("stall_dout_b", {16'b0, dout_b}, model_col(1, got_b.size()));
    end
    pushed_prev[0] = wr_a;
    pushed_prev[1] = wr_b;
    pushed_prev[2] = wr_c;
    if (wr_a) got_a.push_back({16'b0, dout_a});
    if (wr_b) got_b.push_back({16'b0, dout_b});
    if (wr_c) got_c.push_back(dout_c);
    pa = rd_a;
    pb = rd_b;
    pc = rd_c;
    @(posedge clock);
    #1;
    if (pa) src_idx[0]++;
    if (pb) src_idx[1]++;
    if (pc) src_idx[2]++;
    drive_inputs();
  endtask

  task automatic apply_vecs(input int want);
    logic [39:0] act;
    for (int i = 0; i < 9; i++) begin
      if ((vecs[i].dut == 2) != (want == 2)) continue;
      act = 'x;
      case (vecs[i].dut)
        0: if (vecs[i].idx < got_a.size()) act = got_a[vecs[i].idx];
        1: if (vecs[i].idx < got_b.size()) act = got_b[vecs[i].idx];
        default: if (vecs[i].idx < got_c.size()) act = got_c[vecs[i].idx];
      endcase
      check($sformatf("vec%0d_dut%0d_push%0d", i, vecs[i].dut, vecs[i].idx), act, vecs[i].exp);
    end
  endtask

  initial begin
    // Hand-computed columns, lane 0 in the low byte.
    vecs[0] = '{0, 0,  {8'd0, 8'd0, 8'd17, 8'd1,  8'd0}};
    vecs[1] = '{0, 5,  {8'd0, 8'd0, 8'd34, 8'd18, 8'd2}};
    vecs[2] = '{0, 11, {8'd0, 8'd0, 8'd0,  8'd36, 8'd20}};
    vecs[3] = '{1, 0,  {8'd0, 8'd0, 8'd17, 8'd1,  8'd1}};
    vecs[4] = '{1, 6,  {8'd0, 8'd0, 8'd35, 8'd19, 8'd3}};
    vecs[5] = '{1, 8,  {8'd0, 8'd0, 8'd33, 8'd33, 8'd17}};
    vecs[6] = '{1, 11, {8'd0, 8'd0, 8'd36, 8'd36, 8'd20}};
    vecs[7] = '{2, 0,  {8'd33, 8'd17, 8'd1, 8'd0, 8'd0}};
    vecs[8] = '{2, 35, {8'd0, 8'd0, 8'd86, 8'd70, 8'd54}};

    for (int d = 0; d < 3; d++) begin
      src_idx[d] = 0; src_lim[d] = 0; gap_pct[d] = 0; full_pct[d] = 0;
      fd_cnt[d] = 0; pushed_prev[d] = 1'b0;
    end

    // Reset state, with data offered upstream so in_rd_en gating is visible.
    src_lim[0] = 12;
    src_lim[1] = 12;
    drive_inputs();
    #2 reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_rd_a", 40'(rd_a), 40'd0);
    check("rst_wr_a", 40'(wr_a), 40'd0);
    check("rst_dout_a", {16'b0, dout_a}, 40'd0);
    check("rst_fd_a", 40'(fd_a), 40'd0);
    check("rst_dout_b", {16'b0, dout_b}, 40'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    drive_inputs();

    // Zero mode (A) unstalled; replicate mode (B) with a 5-cycle stall mid-RUN.
    for (int cyc = 0; cyc < 40; cyc++) begin
      full_b    = (cyc >= 8 && cyc < 13);
      chk_stall = full_b;
      tick();
    end
    chk_stall = 1'b0;
    full_b    = 1'b0;
    check("pushes_a", 40'(got_a.size()), 40'd12);
    check("pushes_b", 40'(got_b.size()), 40'd12);
    check("frame_done_count_a", 40'(fd_cnt[0]), 40'd1);
    check("frame_done_count_b", 40'(fd_cnt[1]), 40'd1);
    for (int k = 0; k < got_a.size(); k++) check($sformatf("col_a_%0d", k), got_a[k], model_col(0, k));
    for (int k = 0; k < got_b.size(); k++) check($sformatf("col_b_%0d", k), got_b[k], model_col(1, k));
    apply_vecs(0);

    // Reset after 7 pops, then a fresh frame.
    got_a.delete();
    src_idx[0] = 0;
    src_lim[0] = 12;
    src_lim[1] = 0;
    drive_inputs();
    for (int i = 0; i < 40 && src_idx[0] < 7; i++) tick();
    check("pops_before_reset", 40'(src_idx[0]), 40'd7);
    reset = 1'b0;
    #1;
    check("midrst_rd_a", 40'(rd_a), 40'd0);
    check("midrst_wr_a", 40'(wr_a), 40'd0);
    check("midrst_dout_a", {16'b0, dout_a}, 40'd0);
    check("midrst_fd_a", 40'(fd_a), 40'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    got_a.delete();
    src_idx[0] = 0;
    fd_cnt[0] = 0;
    pushed_prev[0] = 1'b0;
    drive_inputs();
    for (int i = 0; i < 40 && fd_cnt[0] == 0; i++) tick();
    check("after_rst_first_col", (got_a.size() > 0) ? got_a[0] : 40'hx, {8'd0, 8'd0, 8'd17, 8'd1, 8'd0});
    check("after_rst_pushes", 40'(got_a.size()), 40'd12);
    check("after_rst_frame_done", 40'(fd_cnt[0]), 40'd1);

    // WIN=5 on 6x6: two frames back to back with random gaps and backpressure.
    src_lim[2]  = 72;
    gap_pct[2]  = 30;
    full_pct[2] = 25;
    drive_inputs();
    for (int i = 0; i < 2000 && !(got_c.size() == 72 && fd_cnt[2] == 2); i++) tick();
    full_pct[2] = 0;
    for (int i = 0; i < 4; i++) tick();
    check("pushes_c", 40'(got_c.size()), 40'd72);
    check("frame_done_count_c", 40'(fd_cnt[2]), 40'd2);
    for (int k = 0; k < got_c.size(); k++) check($sformatf("col_c_%0d", k), got_c[k], model_col(2, k));
    apply_vecs(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sobel_window_feeder.md
SOBEL_WINDOW_FEEDER -- requirements
Module: sobel_window_feeder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- IMG_WIDTH, 720: pixels per row.
- IMG_HEIGHT, 540: rows per frame.
- PIX_DWIDTH, 8: bits per grayscale pixel.
- WIN, 3: window height; odd only, 1..7.
- BORDER_MODE, 0: out-of-image rows; 0 = zero fill, 1 = replicate the nearest valid row.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1: single clock; all state on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- in_dout, in, PIX_DWIDTH: first-word-fall-through upstream FIFO data.
- in_empty, in, 1: upstream FIFO empty.
- in_rd_en, out, 1: pop upstream FIFO.
- out_din, out, WIN*PIX_DWIDTH: window column; lane 0 (LSBs) is the top row, lane WIN-1 the bottom row.
- out_full, in, 1: downstream FIFO full.
- out_wr_en, out, 1: push downstream FIFO.
- frame_done, out, 1: one-cycle pulse after the last column of a frame is pushed.

Function
REQ-003 HALF = (WIN-1)/2; the block SHALL hold WIN-1 line buffers of IMG_WIDTH pixels each.
REQ-004 Input arrives row-major, one pixel per pop; internal row counter r and column counter c SHALL wrap c at IMG_WIDTH-1 and r at IMG_HEIGHT-1.
REQ-005 FSM states SHALL be FILL, RUN and FLUSH; after reset the FSM SHALL be in FILL with r=0 and c=0.
REQ-006 FILL: while r<HALF, the block SHALL pop whenever in_empty=0, store the pixel and produce no output; at the end of row HALF-1 it SHALL go to RUN. When WIN=1, FILL SHALL be skipped.
REQ-007 RUN: each popped pixel (r,c) SHALL produce one column centred at (r-HALF, c); rows <0 or >=IMG_HEIGHT SHALL take the BORDER_MODE value.
REQ-008 After pixel (IMG_HEIGHT-1, IMG_WIDTH-1) the FSM SHALL go to FLUSH when HALF>0, otherwise to FILL.
REQ-009 FLUSH: without popping, the block SHALL emit HALF*IMG_WIDTH columns centred on rows IMG_HEIGHT-HALF..IMG_HEIGHT-1; it SHALL then pulse frame_done and return to FILL.
REQ-010 Each frame SHALL produce exactly IMG_WIDTH*IMG_HEIGHT columns, in raster order of centre pixel.
REQ-011 The output stage SHALL be one register with a valid flag; out_wr_en SHALL equal valid AND NOT out_full, combinationally.
REQ-012 The stage SHALL accept new data when valid=0 or out_full=0.
REQ-013 In RUN, in_rd_en SHALL equal NOT in_empty AND stage-accepts, and SHALL be forced to 0 in FLUSH.
REQ-014 Latency from pop to out_wr_en eligibility SHALL be 1 cycle; throughput SHALL be 1 column per cycle with no bubbles at row or frame boundaries.
REQ-015 While out_full=1, out_din and valid SHALL hold and no pixel SHALL be lost or duplicated.
REQ-016 Replicate mode: the top border SHALL use row 0 and the bottom border SHALL use row IMG_HEIGHT-1, at the same column.
REQ-017 Counter widths SHALL be clog2 of IMG_WIDTH and of IMG_HEIGHT, with no overflow at the maximum values.

Reset
REQ-018 When reset=0: state=FILL, r=0, c=0, valid=0, out_din=0, in_rd_en=0, out_wr_en=0, frame_done=0.
REQ-019 A reset during a frame SHALL abandon that frame; the first pop after release is pixel (0,0) of a new frame. Line buffer contents SHALL NOT need clearing.

Structure
REQ-020 A shared package sobel_pkg SHALL hold the FSM state encodings, the BORDER_ZERO/BORDER_REPLICATE constants and the clog2 function.
REQ-021 One sub-module, sobel_line_ram (single row, IMG_WIDTH x PIX_DWIDTH, combinational read, one write port), SHALL be instantiated WIN-1 times.

Verification
Common settings for scenarios 1-3: IMG_WIDTH=4, IMG_HEIGHT=3, WIN=3; input pixel value = 16r+c+1.
REQ-022 Zero mode:
- First column SHALL be lanes {0,1,17}.
- Last column SHALL be {20,36,0}.
- There SHALL be 12 pushes and one frame_done, asserted after the 12th push.
REQ-023 Replicate mode:
- First column SHALL be {1,1,17}.
- Column centred at (1,2) SHALL be {3,19,35}.
- Last column SHALL be {20,36,36}.
REQ-024 Backpressure: out_full held at 1 for 5 cycles in mid-RUN -> in_rd_en=0 and out_din stable throughout; output sequence identical to the unstalled case.
REQ-025 Reset mid-frame:
- reset=0 asserted after 7 pops -> all outputs 0 immediately.
- A fresh frame afterwards produces a first column of {0,1,17}.
REQ-026 Back-to-back frames with random in_empty gaps and WIN=5 on a 6x6 image -> 36 columns per frame, two frame_done pulses, and column data matches the reference model.
